// File: rtl/dpram_arbiter_pkg.sv
//------------------------------------------------------------------------------
// dpram_arbiter_pkg : shared defaults and FSM encoding for the port-A arbiter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dpram_arbiter_pkg;

    localparam int NREQ_DEFAULT = 4;
    localparam int AW_DEFAULT   = 8 / 2;
    localparam int DW_DEFAULT   = 8;

    localparam int                 STATE_W  = 1;
    localparam logic [STATE_W-1:0] ST_IDLE  = 1'b0;
    localparam logic [STATE_W-1:0] ST_GRANT = 1'b1;

    // Pointer/index width; a single requester still needs a 1-bit field.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dpram_arbiter_rr_pick.sv
//------------------------------------------------------------------------------
// dpram_arbiter_rr_pick : combinational round-robin picker (req, ptr -> winner)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dpram_arbiter_rr_pick
    import dpram_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx,
    output logic            any
);

    int best;

    // The winner is the requester with the smallest forward distance from ptr.
    always_comb begin
        idx  = '0;
        best = NREQ;
        for (int j = 0; j < NREQ; j++) begin
            if (req[j] && (((j + NREQ - int'(ptr)) % NREQ) < best)) begin
                best = (j + NREQ - int'(ptr)) % NREQ;
                idx  = PW'(j);
            end
        end
    end

    assign any    = |req;
    assign onehot = any ? (NREQ'(1) << idx) : '0;

endmodule

`default_nettype wire

// File: rtl/dpram_arbiter.sv
//------------------------------------------------------------------------------
// dpram_arbiter : round-robin arbiter sharing dual-port RAM port A among NREQ
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dpram_arbiter
    import dpram_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int AW   = AW_DEFAULT,
    parameter int DW   = DW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rvalid,
    output logic [DW-1:0]     rdata,
    output logic              ram_we,
    output logic [AW-1:0]     ram_addr,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout
);

    localparam int PW = ptr_width(NREQ);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [PW-1:0]      ptr;
    logic [NREQ-1:0]    win_onehot;
    logic [PW-1:0]      win_idx;
    logic               win_any;
    logic               do_grant;
    logic               sel_we;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_wdata;

    dpram_arbiter_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (win_onehot),
        .idx    (win_idx),
        .any    (win_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (win_any) state_nxt = ST_GRANT;
            ST_GRANT: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        do_grant = (state == ST_IDLE) && win_any;
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (win_idx == PW'(j)) begin
                sel_we    = req_we[j];
                sel_addr  = req_addr[j*AW +: AW];
                sel_wdata = req_wdata[j*DW +: DW];
            end
        end
    end

    // Address and write data are left holding between accesses; ram_we alone qualifies.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            gnt      <= '0;
            rvalid   <= '0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            rvalid <= ((state == ST_GRANT) && !ram_we) ? gnt : '0;
            if (do_grant) begin
                gnt      <= win_onehot;
                ram_we   <= sel_we;
                ram_addr <= sel_addr;
                ram_din  <= sel_wdata;
                ptr      <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
            end else begin
                gnt    <= '0;
                ram_we <= 1'b0;
            end
        end
    end

    assign rdata = ram_dout;

endmodule

`default_nettype wire

// File: doc/dpram_arbiter.md
DPRAM_ARBITER -- requirements
Module: dpram_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing RAM port A.
REQ-002 Parameter AW, default 4, RAM address width (16 locations).
REQ-003 Parameter DW, default 8, RAM data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  NREQ  per-requester access request; held high until granted.
REQ-007 req_we  input  NREQ  per-requester write enable (1 = write, 0 = read).
REQ-008 req_addr  input  NREQ*AW  packed per-requester addresses; slice i = [i*AW +: AW].
REQ-009 req_wdata  input  NREQ*DW  packed per-requester write data; slice i = [i*DW +: DW].
REQ-010 gnt  output  NREQ  one-hot, one-cycle grant pulse.
REQ-011 rvalid  output  NREQ  one-hot, one-cycle read-data-valid pulse.
REQ-012 rdata  output  DW  read data; shared by all requesters, qualified by rvalid.
REQ-013 ram_we  output  1  to RAM port A write enable.
REQ-014 ram_addr  output  AW  to RAM port A address.
REQ-015 ram_din  output  DW  to RAM port A write data.
REQ-016 ram_dout  input  DW  from RAM port A registered read data (1-cycle latency, old data on write).

Function
REQ-017 FSM has two states: IDLE (arbitrate) and GRANT (access in flight); reset state IDLE.
REQ-018 IDLE with req == 0: remain IDLE; gnt, ram_we low.
REQ-019 IDLE with any req bit set: select winner w by round-robin from priority pointer ptr, register gnt = onehot(w), ram_we = req_we[w], ram_addr/ram_din = slice w; next state GRANT.
REQ-020 Round-robin: search order ptr, ptr+1, ..., wrapping modulo NREQ; after grant to w, ptr <= (w+1) mod NREQ, wrapping NREQ-1 -> 0.
REQ-021 GRANT: gnt and ram_* held for exactly one cycle; req ignored; next state IDLE unconditionally; ram_we deasserts on the IDLE entry.
REQ-022 Maximum throughput: one access per two cycles; no back-to-back grants.
REQ-023 Requester whose gnt was high in cycle t+1 deasserts req or presents a new request by cycle t+2; a still-high req in IDLE is a new request.
REQ-024 Read latency: arbitration edge ends cycle t; gnt in t+1; rvalid[w] high in t+2 with rdata = ram_dout (combinational pass-through).
REQ-025 Writes produce no rvalid; gnt is the write completion indication.
REQ-026 ram_addr and ram_din hold last values when idle; only ram_we qualifies an access.
REQ-027 req_we, req_addr, req_wdata of non-winners have no effect.
REQ-028 Port-B write/write collisions to the same address are outside this block's control; system integration prevents them.

Reset
REQ-029 rst high at a rising edge: state IDLE, ptr 0, gnt 0, rvalid 0, ram_we 0, ram_addr 0, ram_din 0.
REQ-030 rst asserted mid-operation (GRANT or pending rvalid) aborts: no rvalid issued after reset; the in-flight RAM write, if ram_we was sampled, is not undone.
REQ-031 First arbitration after reset release favours requester 0.

Structure
REQ-032 Shared package holds NREQ/AW/DW defaults and the FSM state encoding (IDLE, GRANT).
REQ-033 One sub-module, rr_pick: combinational round-robin picker (req, ptr -> one-hot winner, index, any).
REQ-034 Arbiter instantiated beside the dual-port RAM, driving port A only.

Verification
REQ-035 Reset, then req=4'b0001, we=0, addr=3 with mem[3]=8'hA5 -> gnt=0001 one cycle later, rvalid=0001 and rdata=A5 the cycle after.
REQ-036 req=4'b1111 held continuously -> grant order 0,1,2,3,0 on alternate cycles; gnt never high in consecutive cycles.
REQ-037 Requester 2 writes addr=7 data=8'h3C, then requester 1 reads addr=7 -> rvalid=0010, rdata=3C; no rvalid for the write.
REQ-038 ptr at 3 (after grant to 2), req=4'b1001 -> requester 3 granted first, then 0 (wrap).
REQ-039 Read granted, rst asserted in the GRANT cycle -> rvalid stays 0, gnt/ram_we 0 next cycle, next grant favours requester 0.
REQ-040 req=0 for 10 cycles after reset -> gnt, rvalid, ram_we remain 0 throughout.
